// File: rtl/munch_pattern_gen.sv
// munch_pattern_gen: Munching Squares pattern engine for the VGA demo path.
// Produces a registered 2-bit-per-channel RGB stream with syncs delayed to
// match. The frame counter runs from the pixel clock, with a synchronous
// vsync edge detector, a prescaler, pause and reverse.
// Optional feature macro: MUNCH_COLOR_CYCLE_EN (per-sweep colour cycling).
module munch_pattern_gen #(
    parameter int unsigned COORD_W   = 9,
    parameter int unsigned DIV_W     = 4,
    parameter logic        SYNC_IDLE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic               display_on,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   speed,
    input  logic               pause,
    input  logic               reverse,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [COORD_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        PLOT_XOR = 2'b00,
        PLOT_AND = 2'b01,
        PLOT_OR  = 2'b10,
        PLOT_ADD = 2'b11
    } plot_e;

    logic               vsync_q;
    logic               tick;
    logic               advance;
    logic [DIV_W-1:0]   div_cnt;
    plot_e              mode_l;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x_plot;
    logic               h_in;
    logic               v_in;
    logic               lit;
    logic [5:0]         lit_col;
    logic [5:0]         pix_col;

    // Rising edge of vsync seen synchronously; vsync_q resets high so a
    // vsync already high at reset release does not count as an edge.
    assign tick    = vsync & ~vsync_q;
    assign advance = tick & ~pause & (div_cnt >= speed);

    // Frame tick detector, prescaler, frame counter and mode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b1;
            div_cnt   <= '0;
            frame_cnt <= '0;
            mode_l    <= PLOT_XOR;
        end else begin
            vsync_q <= vsync;
            if (tick) begin
                mode_l <= plot_e'(mode);
                if (!pause) begin
                    if (div_cnt >= speed) begin
                        div_cnt   <= '0;
                        frame_cnt <= reverse ? frame_cnt - COORD_W'(1)
                                             : frame_cnt + COORD_W'(1);
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
            end
        end
    end

`ifdef MUNCH_COLOR_CYCLE_EN
    logic [2:0] hue;
    logic [2:0] hue_eff;
    logic       wrap;

    assign wrap = advance & (reverse ? (frame_cnt == '0) : (frame_cnt == '1));

    // Hue steps each time the frame counter wraps, in either direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hue <= '0;
        end else if (wrap) begin
            hue <= hue + 3'd1;
        end
    end

    // Hue 0 is shown as white so the pattern never goes black.
    always_comb begin
        hue_eff = (hue == 3'd0) ? 3'b111 : hue;
        lit_col = {{2{hue_eff[2]}}, {2{hue_eff[1]}}, {2{hue_eff[0]}}};
    end
`else
    assign lit_col = 6'b11_11_11;
`endif

    assign y    = vpos[COORD_W-1:0];
    // Shifting out the field bits leaves zero only when inside the square;
    // at COORD_W=10 the shift is full width so the term is always true.
    assign h_in = ((hpos >> COORD_W) == '0);
    assign v_in = ((vpos >> COORD_W) == '0);

    // Plot function selected by the frame-latched mode.
    always_comb begin
        x_plot = y ^ frame_cnt;
        case (mode_l)
            PLOT_XOR: x_plot = y ^ frame_cnt;
            PLOT_AND: x_plot = y & frame_cnt;
            PLOT_OR:  x_plot = y | frame_cnt;
            PLOT_ADD: x_plot = y + frame_cnt;
            default:  x_plot = y ^ frame_cnt;
        endcase
        lit     = display_on & h_in & v_in & (hpos[COORD_W-1:0] == x_plot);
        pix_col = lit ? lit_col : '0;
    end

    // Output register: colour and syncs share one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            g       <= '0;
            b       <= '0;
            hsync_o <= SYNC_IDLE;
            vsync_o <= SYNC_IDLE;
        end else begin
            r       <= pix_col[5:4];
            g       <= pix_col[3:2];
            b       <= pix_col[1:0];
            hsync_o <= hsync;
            vsync_o <= vsync;
        end
    end

endmodule

// File: tb/tb_munch_pattern_gen.sv
// Scoreboard bench for munch_pattern_gen (default parameters, COORD_W=9).
// Stimulus pushes expected outputs into a queue; the monitor pops one entry
// per clock, one cycle after the inputs were applied.
module tb_munch_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync, vsync;
    logic [1:0] mode;
    logic [3:0] speed;
    logic       pause, reverse;
    logic [1:0] r, g, b;
    logic       hsync_o, vsync_o;
    logic [8:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         chk_pix;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        bit         chk_frm;
        logic [8:0] frm;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] lit_col;

    munch_pattern_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .hsync      (hsync),
        .vsync      (vsync),
        .mode       (mode),
        .speed      (speed),
        .pause      (pause),
        .reverse    (reverse),
        .r          (r),
        .g          (g),
        .b          (b),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle; check one entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_pix) begin
                    checks++;
                    if ({r, g, b} !== e.rgb || hsync_o !== e.hs || vsync_o !== e.vs) begin
                        errors++;
                        $display("FAIL %s: rgb=%b hs=%b vs=%b, required rgb=%b hs=%b vs=%b",
                                 e.name, {r, g, b}, hsync_o, vsync_o, e.rgb, e.hs, e.vs);
                    end
                end
                if (e.chk_frm) begin
                    checks++;
                    if (frame_cnt !== e.frm) begin
                        errors++;
                        $display("FAIL %s: frame_cnt=%0d, required %0d", e.name, frame_cnt, e.frm);
                    end
                end
            end
        end
    end

    function automatic void push_pix(input bit exp_lit, input string nm);
        exp_t e;
        e.chk_pix = 1'b1;
        e.rgb     = exp_lit ? lit_col : 6'b0;
        e.hs      = hsync;
        e.vs      = vsync;
        e.chk_frm = 1'b0;
        e.frm     = '0;
        e.name    = nm;
        exp_q.push_back(e);
    endfunction

    task automatic pix(input int h, input int v, input bit de, input bit hs,
                       input bit exp_lit, input string nm);
        @(negedge clk);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        hsync      = hs;
        push_pix(exp_lit, nm);
    endtask

    task automatic frm(input int f, input string nm);
        exp_t e;
        @(negedge clk);
        e.chk_pix = 1'b0;
        e.rgb     = '0;
        e.hs      = 1'b0;
        e.vs      = 1'b0;
        e.chk_frm = 1'b1;
        e.frm     = 9'(f);
        e.name    = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        display_on = 1'b0;
        vsync      = 1'b1;
        @(negedge clk);
        vsync      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        vsync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sweep one 512-pixel line; lit_h < 0 means no pixel may light.
    task automatic line(input int v, input bit de, input int lit_h, input string nm);
        for (int i = 0; i < 512; i++)
            pix(i, v, de, (i % 5) == 0, i == lit_h, nm);
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b1; hsync = 1'b0; display_on = 1'b1;
        hpos = '0; vpos = '0; mode = 2'b00; speed = '0; pause = 1'b0; reverse = 1'b0;
        lit_col = 6'b111111;

        // Reset held with vsync high: idle syncs, dark pixel, frame 0.
        @(negedge clk);
        begin
            exp_t e;
            e.chk_pix = 1'b1; e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1;
            e.chk_frm = 1'b1; e.frm = '0; e.name = "reset_state";
            exp_q.push_back(e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // vsync still high after release: no tick, frame stays 0.
        pix(0, 0, 1, 1, 1, "post_reset_pix0");
        pix(0, 0, 1, 0, 1, "post_reset_pix1");
        frm(0, "no_spurious_tick");
        vsync = 1'b0;
        frm(0, "no_tick_after_vsync_low");

        // XOR, speed 0: three ticks, line 5 lights hpos 6 only.
        ticks(3);
        frm(3, "xor_frame3");
        line(5, 1, 6, "xor_line5");
        pix(518, 5, 1, 0, 0, "hpos_out_of_range");
        pix(6, 517, 1, 0, 0, "vpos_out_of_range");
        line(480, 0, -1, "blank_line480");

        // Prescaler with speed 2, then pause holds both counters.
        do_reset();
        speed = 4'd2;
        ticks(3);
        frm(1, "presc_3ticks");
        ticks(3);
        frm(2, "presc_6ticks");
        pause = 1'b1;
        ticks(4);
        frm(2, "pause_hold");
        pause = 1'b0;
        ticks(2);
        frm(2, "div_held_2ticks");
        tick();
        frm(3, "div_held_3rd_tick");

        // Reverse wrap from 0, then ADD latched by a paused tick.
        do_reset();
        speed = '0; reverse = 1'b1;
`ifdef MUNCH_COLOR_CYCLE_EN
        lit_col = 6'b000011;
`endif
        tick();
        frm(511, "reverse_wrap");
        mode = 2'b11;
        pix(501, 10, 1, 0, 1, "add_pending_xor_lit");
        pix(9, 10, 1, 0, 0, "add_pending_9_dark");
        pause = 1'b1;
        tick();
        pause = 1'b0; reverse = 1'b0;
        frm(511, "paused_latch_tick");
        pix(9, 10, 1, 0, 1, "add_lit_9");
        pix(501, 10, 1, 0, 0, "add_501_dark");
        pix(8, 10, 1, 0, 0, "add_8_dark");

        // Mid-frame mode change XOR -> AND.
        do_reset();
        lit_col = 6'b111111;
        mode = 2'b00;
        tick();
        frm(1, "midframe_frame1");
        pix(7, 6, 1, 0, 1, "xor_7_lit");
        mode = 2'b01;
        pix(7, 6, 1, 1, 1, "midframe_still_xor");
        pix(0, 6, 1, 0, 0, "midframe_and_not_yet");
        // Pixel in the tick cycle itself uses the old frame and mode.
        @(negedge clk);
        vsync = 1'b1; hpos = 10'd7; vpos = 10'd6; display_on = 1'b1; hsync = 1'b0;
        push_pix(1'b1, "tick_cycle_old_values");
        @(negedge clk);
        vsync = 1'b0;
        frm(2, "and_frame2");
        pix(2, 6, 1, 0, 1, "and_2_lit");
        pix(4, 6, 1, 0, 0, "and_xor_pos_dark");
        mode = 2'b10;
        tick();
        pix(7, 5, 1, 0, 1, "or_7_lit");
        pix(6, 5, 1, 0, 0, "or_xor_pos_dark");

        // Full sweep of 512 ticks: frame wraps to 0 once.
        do_reset();
        mode = 2'b00;
        pix(3, 3, 1, 0, 1, "hue0_white");
        ticks(512);
        frm(0, "sweep_wrap");
`ifdef MUNCH_COLOR_CYCLE_EN
        lit_col = 6'b000011;
`endif
        pix(3, 3, 1, 1, 1, "sweep_colour");
        pix(4, 3, 1, 1, 0, "sweep_dark");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/munch_pattern_gen.md
# munch_pattern_gen

Parametrised Munching Squares pattern engine for the VGA demo path. It sits between `hvsync_generator` and the Tiny VGA Pmod pin mapping, and generates a registered 2-bit-per-channel RGB pixel stream plus delay-matched syncs. Compared with the single-mode demo it adds:
- a selectable plot function;
- a frame-rate prescaler, pause and reverse;
- a frame counter clocked from the pixel clock with synchronous vsync edge detection;
- an optional per-sweep colour cycle.

## Interface
- `COORD_W`, 9, plot-field width in bits: the square is 2^COORD_W pixels; legal range 4..10.
- `DIV_W`, 4, width of the speed prescaler.
- `SYNC_IDLE`, 1'b1, reset and idle level of `hsync_o` and `vsync_o`.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `hpos` in 10: horizontal position from the sync generator.
- `vpos` in 10: vertical position from the sync generator.
- `display_on` in 1: visible-area flag.
- `hsync` in 1: raw horizontal sync.
- `vsync` in 1: raw vertical sync.
- `mode` in 2: plot function; 00 XOR, 01 AND, 10 OR, 11 ADD.
- `speed` in DIV_W: the frame counter advances once every `speed`+1 frames.
- `pause` in 1: hold the frame counter.
- `reverse` in 1: count the frame counter down.
- `r`, `g`, `b` out 2 each: pixel colour.
- `hsync_o`, `vsync_o` out 1 each: syncs delayed by one cycle.
- `frame_cnt` out COORD_W: current frame phase.

## Operation
**Frame tick**
- `vsync_q` samples `vsync` every clock.
- `tick` = `vsync` & ~`vsync_q`, i.e. a rising edge detected synchronously. No logic is clocked by `vsync`.

**Prescaler** (`div_cnt`, DIV_W bits)
On a tick with `pause`=0:
- If `div_cnt` >= `speed`: clear `div_cnt` and advance `frame_cnt` by +1, or by -1 when `reverse`=1. The step is modulo 2^COORD_W.
- Otherwise: increment `div_cnt`.

The >= comparison means that lowering `speed` mid-count cannot cause a long wrap. When `pause`=1, both `div_cnt` and `frame_cnt` hold. `speed`, `pause` and `reverse` are sampled only on tick cycles.

**Mode latch**
- `mode_l` loads `mode` on every tick.
- Mode changes therefore take effect only at frame boundaries and never tear mid-frame.

**Plot**
- `y` = `vpos`[COORD_W-1:0] and `f` = `frame_cnt`.
- `x_plot` = y^f, y&f, y|f, or (y+f) mod 2^COORD_W, selected by `mode_l`.
- `lit` = `display_on` & (`hpos` < 2^COORD_W) & (`vpos` < 2^COORD_W) & (`hpos`[COORD_W-1:0] == `x_plot`).
- When COORD_W=10, both range terms are constant true.

**Colour**
- Without the colour feature, a lit pixel is white (`r`=`g`=`b`=2'b11).
- An unlit pixel is always 2'b00 on all channels.

## Timing
- Reset values: `r`, `g`, `b` = 0; `hsync_o` = `vsync_o` = SYNC_IDLE; `frame_cnt` = 0; `div_cnt` = 0; `mode_l` = 0 (XOR); `vsync_q` = 1, so no spurious tick occurs if `vsync` is high when reset releases.
- Pixel latency is exactly 1 cycle. `r`/`g`/`b` at cycle n+1 reflect `hpos`/`vpos`/`display_on` at cycle n. `hsync_o`/`vsync_o` are registered copies of `hsync`/`vsync`, so colour and syncs stay aligned.
- On a tick, `frame_cnt` and `mode_l` update on that clock edge. The pixel computed in the same cycle uses the old values.
- Reset asserted mid-frame clears all state immediately and asynchronously. The first tick after release requires `vsync` to have been seen low.
- `frame_cnt` wrap: with reverse=0, 2^COORD_W-1 goes to 0; with reverse=1, 0 goes to 2^COORD_W-1.

## Configuration
- Macro `MUNCH_COLOR_CYCLE_EN`.
- **Defined:**
  - A 3-bit `hue` register is added, reset to 0.
  - `hue` increments whenever `frame_cnt` wraps in either direction.
  - A lit pixel outputs `r`={2{h[2]}}, `g`={2{h[1]}}, `b`={2{h[0]}}, where h = `hue`, except that `hue`=000 maps to 111 so the pattern is never black.
- **Undefined:** no `hue` register exists, and lit pixels are white.

## Test plan
- **Reset and edge detect:** hold `rst_n`=0 with `vsync`=1, then release. Required: no tick occurs; all colour outputs are 0; `hsync_o`/`vsync_o` = 1; `frame_cnt`=0.
- **XOR, speed 0:** COORD_W=9. After 3 vsync rising edges, `frame_cnt`=3. At `vpos`=5 and `display_on`=1, exactly one lit pixel appears on the line, at `hpos`=6. It appears one cycle late and aligned with `hsync_o`. The line at `vpos`=480 shows no lit pixels.
- **Prescaler and pause:** `speed`=2, with 6 ticks → `frame_cnt`=2. Then `pause`=1 with 4 ticks → `frame_cnt` stays 2 and `div_cnt` holds.
- **Reverse wrap and ADD:** from `frame_cnt`=0 with `reverse`=1, one tick → 511. Then `mode`=11: the line at `vpos`=10 lights `hpos`=9 only on the frame after the tick that latched the mode.
- **Mid-frame mode change:** change `mode` from XOR to AND mid-frame. Required: the rest of that frame is plotted with XOR; AND applies from the next tick.
- **Colour cycle:** with `MUNCH_COLOR_CYCLE_EN` defined, run 512 ticks at `speed`=0. Required: `hue`=1 and a lit pixel shows `r`=00, `g`=00, `b`=11. With `hue`=0, a lit pixel shows 11/11/11.
